// File: rtl/axi_lite_master_if.sv
// Bundle of the command/result streams and the AXI4-Lite channels of the initiator.
// The master modport is the initiator's view; slave is the environment's view.
`timescale 1ns/1ps
interface axi_lite_master_if #(
  parameter int ADDR_N = 9,
  parameter int DATA_N = 32
);
  logic                  cmd_write;
  logic [ADDR_N-1:0]     cmd_addr;
  logic [DATA_N-1:0]     cmd_data;
  logic                  cmd_valid;
  logic                  cmd_ready;

  logic [DATA_N-1:0]     rsp_data;
  logic                  rsp_err;
  logic                  rsp_write;
  logic                  rsp_valid;
  logic                  rsp_ready;

  logic [ADDR_N-1:0]     m_axi_awaddr;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;

  logic [DATA_N-1:0]     m_axi_wdata;
  logic [DATA_N/8-1:0]   m_axi_wstrb;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;

  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  logic [ADDR_N-1:0]     m_axi_araddr;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;

  logic [DATA_N-1:0]     m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  cmd_write, cmd_addr, cmd_data, cmd_valid,
    output cmd_ready,
    output rsp_data, rsp_err, rsp_write, rsp_valid,
    input  rsp_ready,
    output m_axi_awaddr, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output cmd_write, cmd_addr, cmd_data, cmd_valid,
    input  cmd_ready,
    input  rsp_data, rsp_err, rsp_write, rsp_valid,
    output rsp_ready,
    input  m_axi_awaddr, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi_lite_master.sv
// Command-to-AXI4-Lite initiator: one read or write command in, one AXI4-Lite
// transaction out, one result back. Only a single transaction is ever in flight.
`timescale 1ns/1ps
module axi_lite_master #(
  parameter int ADDR_N = 9,
  parameter int DATA_N = 32
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  axi_lite_master_if.master     bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_RSP   = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                cmd_ready;
  logic                cmd_fire;
  logic                aw_fire;
  logic                w_fire;
  logic                b_fire;
  logic                ar_fire;
  logic                r_fire;
  logic                rsp_fire;
  logic                aw_done;
  logic                w_done;

  logic [ADDR_N-1:0]   awaddr_q;
  logic [ADDR_N-1:0]   araddr_q;
  logic [DATA_N-1:0]   wdata_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                rsp_valid_q;
  logic [DATA_N-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic                rsp_write_q;

  // Only xRESP[1] distinguishes an error; the low bit carries no extra meaning here.
  logic                unused_resp;
  assign unused_resp = bus.m_axi_bresp[0] ^ bus.m_axi_rresp[0];

  assign cmd_ready = (state == S_IDLE) & m_axi_aresetn;
  assign cmd_fire  = bus.cmd_valid & cmd_ready;
  assign aw_fire   = awvalid_q & bus.m_axi_awready;
  assign w_fire    = wvalid_q & bus.m_axi_wready;
  assign b_fire    = bready_q & bus.m_axi_bvalid;
  assign ar_fire   = arvalid_q & bus.m_axi_arready;
  assign r_fire    = rready_q & bus.m_axi_rvalid;
  assign rsp_fire  = rsp_valid_q & bus.rsp_ready;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          state_nxt = bus.cmd_write ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        // AW and W complete independently; leave once both have been taken.
        if ((aw_done | aw_fire) & (w_done | w_fire)) begin
          state_nxt = S_WRESP;
        end
      end
      S_WRESP: begin
        if (b_fire) begin
          state_nxt = S_RSP;
        end
      end
      S_RADDR: begin
        if (ar_fire) begin
          state_nxt = S_RDATA;
        end
      end
      S_RDATA: begin
        if (r_fire) begin
          state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_fire) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      aw_done   <= cmd_fire ? 1'b0 : (aw_done | aw_fire);
      w_done    <= cmd_fire ? 1'b0 : (w_done | w_fire);
      // A valid stays up until its own handshake, then drops for good.
      awvalid_q <= (state_nxt == S_WADDR) &
                   (cmd_fire ? 1'b1 : (awvalid_q & ~aw_fire));
      wvalid_q  <= (state_nxt == S_WADDR) &
                   (cmd_fire ? 1'b1 : (wvalid_q & ~w_fire));
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      bready_q    <= (state_nxt == S_WRESP);
      arvalid_q   <= (state_nxt == S_RADDR);
      rready_q    <= (state_nxt == S_RDATA);
      rsp_valid_q <= (state_nxt == S_RSP);
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      awaddr_q    <= '0;
      wdata_q     <= '0;
      araddr_q    <= '0;
      rsp_write_q <= 1'b0;
    end else if (cmd_fire) begin
      rsp_write_q <= bus.cmd_write;
      if (bus.cmd_write) begin
        awaddr_q <= bus.cmd_addr;
        wdata_q  <= bus.cmd_data;
      end else begin
        araddr_q <= bus.cmd_addr;
      end
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (b_fire) begin
      rsp_data_q <= '0;
      rsp_err_q  <= bus.m_axi_bresp[1];
    end else if (r_fire) begin
      rsp_data_q <= bus.m_axi_rdata;
      rsp_err_q  <= bus.m_axi_rresp[1];
    end
  end

  assign bus.cmd_ready     = cmd_ready;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.rsp_write     = rsp_write_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.m_axi_awaddr  = awaddr_q;
  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_wdata   = wdata_q;
  assign bus.m_axi_wstrb   = '1;
  assign bus.m_axi_wvalid  = wvalid_q;
  assign bus.m_axi_bready  = bready_q;
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready_q;

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Command-to-AXI4-Lite initiator: accepts one read or write command per handshake on a simple valid/ready stream and issues it as a single AXI4-Lite transaction. It returns the read data and response status on a result stream. It is the initiator counterpart to the generated AXI-Lite slave wrappers, and it drives those wrappers from benches and from on-chip controllers. At most one transaction is outstanding at any time.

## Interface
- `ADDR_N`, default 9: address width.
- `DATA_N`, default 32: data width. Must be a multiple of 8.

- `m_axi_aclk`  in  1  clock; all logic is on the rising edge.
- `m_axi_aresetn`  in  1  asynchronous, active-low reset.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_N  transaction address.
- `cmd_data`  in  DATA_N  write data; ignored for reads.
- `cmd_valid`  in  1  command handshake.
- `cmd_ready`  out  1  command handshake.
- `rsp_data`  out  DATA_N  read data; 0 for writes.
- `rsp_err`  out  1  `xRESP[1]` of the completed transaction (SLVERR or DECERR).
- `rsp_write`  out  1  echoes `cmd_write`.
- `rsp_valid`  out  1  result handshake.
- `rsp_ready`  in  1  result handshake.
- `m_axi_awaddr` out ADDR_N, `m_axi_awvalid` out 1, `m_axi_awready` in 1.
- `m_axi_wdata` out DATA_N, `m_axi_wstrb` out DATA_N/8 (constant all-ones), `m_axi_wvalid` out 1, `m_axi_wready` in 1.
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1.
- `m_axi_araddr` out ADDR_N, `m_axi_arvalid` out 1, `m_axi_arready` in 1.
- `m_axi_rdata` in DATA_N, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1.

## Operation
- **States:** IDLE, WADDR (AW/W phase), WRESP, RADDR, RDATA, RSP.
- **IDLE:**
  - `cmd_ready = (state==IDLE) & m_axi_aresetn`.
  - On `cmd_valid & cmd_ready`, register addr and data into the AW/AR and W registers.
  - Go to WADDR if `cmd_write`, else RADDR.
- **WADDR:**
  - `awvalid` and `wvalid` rise together.
  - Each one clears on its own handshake, tracked by `aw_done` and `w_done`.
  - Go to WRESP on the cycle both are done. This includes both handshakes in the same cycle, or the second one completing.
- **WRESP:**
  - `bready = 1`.
  - On `bvalid`: `rsp_err <= bresp[1]`, `rsp_data <= 0`, go to RSP.
- **RADDR:**
  - `arvalid = 1`.
  - On `arready`, go to RDATA.
- **RDATA:**
  - `rready = 1`.
  - On `rvalid`: `rsp_data <= rdata`, `rsp_err <= rresp[1]`, go to RSP.
- **RSP:**
  - `rsp_valid = 1`; `rsp_data`, `rsp_err` and `rsp_write` are held stable.
  - On `rsp_ready`, go to IDLE.
- **Address and data stability:** `awaddr`, `wdata` and `araddr` are stable while the corresponding valid is high. Once raised, a valid never drops before its handshake completes.
- **Unknown state:** any unreachable state encoding returns to IDLE.
- **Reset:**
  - Asserting `m_axi_aresetn` low at any time, including mid-transaction, forces state to IDLE immediately.
  - All outputs go to 0 (except `wstrb`). The in-flight transaction is dropped and no result is produced.

## Timing
- **Reset values:** all valid and ready outputs are 0, including `cmd_ready`. `awaddr`, `araddr`, `wdata`, `rsp_data`, `rsp_err` and `rsp_write` are 0.
- **All outputs are registered,** except `cmd_ready`, which is decoded from state.
- **Write with a zero-wait slave:**
  - cycle 0: command accepted;
  - cycle 1: AW and W handshakes;
  - cycle 2: B handshake;
  - cycle 3: `rsp_valid` high.
- **Read with a zero-wait slave:**
  - cycle 0: command accepted;
  - cycle 1: AR handshake;
  - cycle 2: R handshake;
  - cycle 3: `rsp_valid` high.
- **Turnaround:** if `rsp_ready` is high in the first RSP cycle, `cmd_ready` is high on the next cycle. Peak throughput is one transaction per 4 cycles.
- **Back-pressure:** `bready` and `rready` are high only in WRESP and RDATA respectively. No AXI channel is active during RSP or IDLE.

## Test plan
- **Write, zero-wait slave:** write 0x010 ← 0xDEADBEEF. Required: `awaddr=0x010`, `wdata=0xDEADBEEF`, `wstrb=4'hF`; `rsp_valid` at cycle 3 with `rsp_write=1`, `rsp_err=0`, `rsp_data=0`.
- **Read-back:** read 0x010 from a slave returning 0xDEADBEEF/OKAY. Required: `araddr=0x010`; `rsp_valid` at cycle 3 with `rsp_data=0xDEADBEEF`, `rsp_err=0`, `rsp_write=0`.
- **Skewed write channels:** `awready` delayed 3 cycles, `wready` immediate. Required: `wvalid` drops after cycle 1; `awvalid` is held through cycle 4; `bready` rises only at cycle 5.
- **Error response:** bresp=2'b10 on a write, then rresp=2'b11 on a read. Required: `rsp_err=1` for both; `rsp_data=0` on the write.
- **Result back-pressure:** hold `rsp_ready` low for 5 cycles. Required: `rsp_*` stable, `cmd_ready=0`, and no AXI valid/ready asserted until 1 cycle after `rsp_ready`.
- **Reset mid-read:** assert reset during RDATA. Required: `rready` and `cmd_ready` go to 0 without waiting for a clock edge; after release, `cmd_ready=1` on the first edge and `rsp_valid` never asserts.
